sram_confreg: RTL

SRAM_CONFREG -- requirements
Module: sram_confreg

---
 rtl/sram_confreg_if.sv | 12 +
 rtl/sram_confreg.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sram_confreg_if.sv
// Request/response bus of the configuration register block: one request per cycle,
// with the read data returned one cycle later.
interface sram_confreg_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, output wen, output addr, output wdata, input rdata);
  modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/sram_confreg.sv
// Memory-mapped configuration registers: scratch words, free-running timer with
// sticky compare interrupt, LED, synchronised switches, seven-segment NUM and a simulation flag.
module sram_confreg #(
  parameter logic [15:0] BASE_HI   = 16'hBFAF,
  parameter logic        SIMU_FLAG = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  sram_confreg_if.slave bus,
  input  logic [15:0]   switch_i,
  output logic [15:0]   led_o,
  output logic [31:0]   num_o,
  output logic          timer_int_o
);

  localparam logic [15:0] OFF_SCR0    = 16'h0000;
  localparam logic [15:0] OFF_SCR1    = 16'h0004;
  localparam logic [15:0] OFF_SCR2    = 16'h0008;
  localparam logic [15:0] OFF_SCR3    = 16'h000C;
  localparam logic [15:0] OFF_TIMER   = 16'hE000;
  localparam logic [15:0] OFF_COMPARE = 16'hE004;
  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_SWITCH  = 16'hF010;
  localparam logic [15:0] OFF_NUM     = 16'hF020;
  localparam logic [15:0] OFF_SIMU    = 16'hF030;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = be[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
    end
    return res;
  endfunction

  logic [31:0] scr_q [4];
  logic [31:0] scr_d [4];
  logic [31:0] timer_q, timer_d;
  logic [31:0] compare_q, compare_d;
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic        int_q, int_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] sw_meta_q, sw_sync_q;

  logic        hit_s;
  logic        wr_s;
  logic        rd_s;
  logic [15:0] off_s;
  logic [31:0] sel_s;
  logic [31:0] wmerge_s;
  logic        unused_s;

  assign hit_s    = bus.en && (bus.addr[31:16] == BASE_HI);
  assign wr_s     = hit_s && (bus.wen != 4'h0);
  assign rd_s     = bus.en && (bus.wen == 4'h0);
  assign off_s    = {bus.addr[15:2], 2'b00};
  assign unused_s = ^bus.addr[1:0];

  // Read multiplexer over the register map.
  always_comb begin
    sel_s = 32'h0;
    case (off_s)
      OFF_SCR0:    sel_s = scr_q[0];
      OFF_SCR1:    sel_s = scr_q[1];
      OFF_SCR2:    sel_s = scr_q[2];
      OFF_SCR3:    sel_s = scr_q[3];
      OFF_TIMER:   sel_s = timer_q;
      OFF_COMPARE: sel_s = compare_q;
      OFF_LED:     sel_s = {16'h0000, led_q};
      OFF_SWITCH:  sel_s = {16'h0000, sw_sync_q};
      OFF_NUM:     sel_s = num_q;
      OFF_SIMU:    sel_s = {31'h0, SIMU_FLAG};
      default:     sel_s = 32'h0;
    endcase
  end

  // Byte-merged write value, taken against the pre-write register contents.
  always_comb begin
    wmerge_s = 32'h0;
    case (off_s)
      OFF_SCR0:    wmerge_s = byte_merge(scr_q[0], bus.wdata, bus.wen);
      OFF_SCR1:    wmerge_s = byte_merge(scr_q[1], bus.wdata, bus.wen);
      OFF_SCR2:    wmerge_s = byte_merge(scr_q[2], bus.wdata, bus.wen);
      OFF_SCR3:    wmerge_s = byte_merge(scr_q[3], bus.wdata, bus.wen);
      OFF_TIMER:   wmerge_s = byte_merge(timer_q, bus.wdata, bus.wen);
      OFF_COMPARE: wmerge_s = byte_merge(compare_q, bus.wdata, bus.wen);
      OFF_LED:     wmerge_s = byte_merge({16'h0000, led_q}, bus.wdata, bus.wen);
      OFF_NUM:     wmerge_s = byte_merge(num_q, bus.wdata, bus.wen);
      default:     wmerge_s = 32'h0;
    endcase
  end

  // Next-state for the register file, timer, interrupt flag and read data.
  always_comb begin
    scr_d     = scr_q;
    timer_d   = timer_q + 32'd1;
    compare_d = compare_q;
    led_d     = led_q;
    num_d     = num_q;
    if (wr_s) begin
      case (off_s)
        OFF_SCR0:    scr_d[0]  = wmerge_s;
        OFF_SCR1:    scr_d[1]  = wmerge_s;
        OFF_SCR2:    scr_d[2]  = wmerge_s;
        OFF_SCR3:    scr_d[3]  = wmerge_s;
        OFF_TIMER:   timer_d   = wmerge_s;
        OFF_COMPARE: compare_d = wmerge_s;
        OFF_LED:     led_d     = wmerge_s[15:0];
        OFF_NUM:     num_d     = wmerge_s;
        default:     scr_d     = scr_q;
      endcase
    end else begin
      scr_d = scr_q;
    end

    // A COMPARE write wins over a match; the new COMPARE is only looked at next cycle.
    if (wr_s && (off_s == OFF_COMPARE)) begin
      int_d = 1'b0;
    end else if (timer_d == compare_q) begin
      int_d = 1'b1;
    end else begin
      int_d = int_q;
    end

    if (rd_s) begin
      rdata_d = hit_s ? sel_s : 32'h0;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        scr_q[i] <= 32'h0;
      end
      timer_q   <= 32'h0;
      compare_q <= 32'hFFFF_FFFF;
      led_q     <= 16'hFFFF;
      num_q     <= 32'h0;
      int_q     <= 1'b0;
      rdata_q   <= 32'h0;
      sw_meta_q <= 16'h0000;
      sw_sync_q <= 16'h0000;
    end else begin
      scr_q     <= scr_d;
      timer_q   <= timer_d;
      compare_q <= compare_d;
      led_q     <= led_d;
      num_q     <= num_d;
      int_q     <= int_d;
      rdata_q   <= rdata_d;
      sw_meta_q <= switch_i;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign bus.rdata   = rdata_q;
  assign led_o       = led_q;
  assign num_o       = num_q;
  assign timer_int_o = int_q;

endmodule
